// File: rtl/rca_multibyte_controller_pkg.sv
// Shared types and constants for the multi-byte ripple-carry adder controller.
// State encodings are fixed so any adder arbiter can decode them the same way.
package rca_multibyte_controller_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Signed overflow from the top byte's operand and sum sign bits.
   function automatic logic ovf_bit(
      input logic a_msb,
      input logic b_msb,
      input logic s_msb
   );
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/rca_multibyte_controller_rca.sv
// 8-bit ripple-carry adder datapath built from a chain of full adders.
// Interface (a, b, cin, cout, sum) is shared with the rest of the lab datapath.
module Ripple_Carry_Adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] w_c;

   assign w_c[0] = cin;

   for (genvar g = 0; g < 8; g++) begin : g_fa
      assign sum[g]   = a[g] ^ b[g] ^ w_c[g];
      assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
   end

   assign cout = w_c[8];

endmodule

// File: rtl/rca_multibyte_controller.sv
// Multi-precision add/subtract front end: walks one 8-bit ripple adder over
// NBYTES bytes, LSB first, carrying between bytes in a register.
import rca_multibyte_controller_pkg::*;

module rca_multibyte_controller #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic [8*NBYTES-1:0]   op_a,
   input  logic [8*NBYTES-1:0]   op_b,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  cout,
   output logic                  overflow
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic            r_carry;
   logic            r_sub;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_result;
   logic            r_cout;
   logic            r_ovf;
   logic            r_busy;
   logic            r_done;

   logic [IW+2:0]   w_bit;
   logic [7:0]      w_a;
   logic [7:0]      w_b;
   logic [7:0]      w_sum;
   logic            w_cout;
   logic            w_last;

   // Byte lane offset is idx*8, formed by concatenation.
   assign w_bit  = {r_idx, 3'b000};
   assign w_a    = r_a[w_bit +: 8];
   assign w_b    = r_b[w_bit +: 8] ^ {8{r_sub}};
   assign w_last = (r_idx == LAST_IDX);

   Ripple_Carry_Adder u_rca (
      .a    (w_a),
      .b    (w_b),
      .cin  (r_carry),
      .cout (w_cout),
      .sum  (w_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_sub    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_sub   <= sub;
                  r_carry <= sub;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_result[w_bit +: 8] <= w_sum;
               r_carry              <= w_cout;
               if (w_last) begin
                  r_cout  <= w_cout;
                  r_ovf   <= ovf_bit(r_a[W-1], w_b[7], w_sum[7]);
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_result;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_rca_multibyte_controller.sv
// Directed and random checks of the multi-byte adder controller against
// a signed/unsigned arithmetic reference model.
module tb_rca_multibyte_controller;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          sub;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          cout;
   logic          overflow;

   int total;
   int bad;

   rca_multibyte_controller #(.NBYTES(NB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, output logic [W-1:0] r,
                                 output logic c, output logic v);
      longint ua, ub, ur, sa, sb, sr;
      ua = a;
      ub = b;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         ur = ua - ub;
         c  = (ua >= ub);
         sr = sa - sb;
      end else begin
         ur = ua + ub;
         c  = (ur > 64'sd4294967295);
         sr = sa + sb;
      end
      r = ur[W-1:0];
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endfunction

   task automatic run_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
      logic [W-1:0] er;
      logic ec, ev;
      model(a, b, s, er, ec, ev);
      @(negedge clk);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      sub   = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
      sub   = ~s;
      chk({tag, ".busy_e0"}, W'(busy), W'(1));
      for (int k = 1; k <= NB; k++) begin
         @(posedge clk);
         #1;
         if (k < NB) begin
            chk({tag, ".done_early"}, W'(done), W'(0));
         end else begin
            chk({tag, ".done"}, W'(done), W'(1));
            chk({tag, ".result"}, result, er);
            chk({tag, ".cout"}, W'(cout), W'(ec));
            chk({tag, ".ovf"}, W'(overflow), W'(ev));
         end
      end
      @(posedge clk);
      #1;
      chk({tag, ".busy_end"}, W'(busy), W'(0));
      chk({tag, ".done_end"}, W'(done), W'(0));
      chk({tag, ".held"}, result, er);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic rs;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", W'(busy), W'(0));
      chk("rst.done", W'(done), W'(0));
      chk("rst.result", result, '0);
      chk("rst.cout", W'(cout), W'(0));
      chk("rst.ovf", W'(overflow), W'(0));
      @(negedge clk);
      rst_n = 1'b1;

      run_op("carry", 32'h0000_00FF, 32'h0000_0001, 1'b0);
      run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_op("addovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      run_op("borrow", 32'h0000_0000, 32'h0000_0001, 1'b1);
      run_op("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1);

      // Busy protection: re-pulses at E2 and in the done cycle are ignored.
      @(negedge clk);
      start = 1'b1;
      op_a  = 32'h1111_1111;
      op_b  = 32'h2222_2222;
      sub   = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      op_a  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("busyp.done", W'(done), W'(1));
      chk("busyp.result", result, 32'h3333_3333);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busyp.busy_e5", W'(busy), W'(0));
      chk("busyp.result_e5", result, 32'h3333_3333);
      @(posedge clk);
      #1;
      chk("busyp.still_idle", W'(busy), W'(0));

      // Reset in the middle of a run clears everything at once.
      @(negedge clk);
      start = 1'b1;
      op_a  = 32'hDEAD_BEEF;
      op_b  = 32'h1234_5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst.busy", W'(busy), W'(0));
      chk("midrst.done", W'(done), W'(0));
      chk("midrst.result", result, '0);
      chk("midrst.cout", W'(cout), W'(0));
      chk("midrst.ovf", W'(overflow), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_op("afterrst", 32'h0000_0005, 32'h0000_0003, 1'b1);

      for (int n = 0; n < 24; n++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (n % 6 == 0) rb = ra;
         run_op($sformatf("rand%0d", n), ra, rb, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
